tank_actuator_seq: RTL
======================

Name: tank_actuator_seq

Overview:
- Responder side of the 2-bit irrigation state code (00 NADA, 01 ADB, 10 LIMP) produced by the tank supervisory FSM.
- Converts each commanded code into a timed actuator sequence: fertilizer dosing, or a drain/rinse/flush cleaning cycle.
- Drives the inlet, fertilizer and outlet valves; returns completion pulses and fault status to the supervisor.
- Sits between the supervisory FSM and the valve drivers / level sensors.

Parameters:
- DOSE_CYCLES, 8: cycles valve_adb is held open per dose.
- DRAIN_CYCLES, 16: timeout for reaching level_low while draining or flushing.
- RINSE_CYCLES, 12: timeout for reaching level_high while rinsing.
- CW, 5: counter width. Requirement: 2^CW >= max(DOSE_CYCLES, DRAIN_CYCLES, RINSE_CYCLES).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- resetN  input  1  asynchronous, active-high reset.
- cmd  input  2  state code from supervisor: 00 NADA, 01 ADB, 10 LIMP, 11 reserved (treated as NADA).
- level_low  input  1  tank at/below low mark.
- level_high  input  1  tank at/above high mark.
- critico  input  1  critical condition; forces safe shutdown.
- valve_in  output  1  inlet (water) valve open.
- valve_adb  output  1  fertilizer valve open.
- valve_out  output  1  outlet/drain valve open.
- adb_done  output  1  one-cycle pulse: dose completed.
- limp_done  output  1  one-cycle pulse: cleaning cycle completed.
- busy  output  1  high in DOSE, DRAIN, RINSE, FLUSH.
- fault  output  1  high in FAULT.
- phase  output  3  current state encoding.

Behaviour:
- States and phase encoding: IDLE 0, DOSE 1, DRAIN 2, RINSE 3, FLUSH 4, HOLD 5, FAULT 6. Codes 7 and unused go to IDLE on the next edge.
- Reset (resetN=1, async): state IDLE, counter 0, served-cmd register 00. All outputs 0; phase 0.
- Outputs are decoded from registered state (Moore). Valve rises on the first cycle after the edge that samples the triggering cmd.
- Valve mapping: DOSE → valve_adb; DRAIN and FLUSH → valve_out; RINSE → valve_in. Otherwise all valves 0. At most one valve is high at any time.
- Counter: cleared on every state entry, increments each cycle within a state, saturates at 2^CW-1.
- Transition priority per edge: critico, then cmd abort, then level condition, then timeout.
- IDLE:
  - cmd=01 → DOSE, served←01.
  - cmd=10 → DRAIN, served←10.
  - 00 or 11: stay.
- DOSE: when counter = DOSE_CYCLES-1 → HOLD. valve_adb is high for exactly DOSE_CYCLES cycles.
- DRAIN:
  - level_low=1 → RINSE.
  - Else counter = DRAIN_CYCLES-1 → FAULT.
- RINSE:
  - level_high=1 → FLUSH.
  - Else counter = RINSE_CYCLES-1 → FAULT.
- FLUSH:
  - level_low=1 → HOLD.
  - Else counter = DRAIN_CYCLES-1 → FAULT.
- Level vs timeout: if the level condition and the timeout occur on the same cycle, the level condition wins (no fault).
- HOLD:
  - adb_done (served=01) or limp_done (served=10) is high for exactly the first HOLD cycle.
  - Remain while cmd = served. Any other cmd → IDLE. The same command is never re-executed without an intervening change.
- Abort: cmd=00 or 11 while in DOSE/DRAIN/RINSE/FLUSH → IDLE next edge, valves closed, no done pulse, no fault. Any other cmd change mid-sequence is ignored until HOLD.
- critico=1 in any state except FAULT → FAULT next edge; all valves 0 from that cycle.
- FAULT: exit to IDLE only when cmd=00 and critico=0 on the same edge.
- Reset mid-sequence: immediate return to reset values, valves drop asynchronously.

Test Plan:
- Reset, then cmd=01 held → valve_adb high for exactly 8 cycles, phase 1→5, adb_done pulse 1 cycle. Stays HOLD while cmd=01; cmd=00 → IDLE next edge.
- cmd=10; level_low at DRAIN cycle 5; level_high at RINSE cycle 4; level_low at FLUSH cycle 3 → phases 2→3→4→5, valve sequence out/in/out, limp_done single pulse.
- cmd=10, level_low never asserted → valve_out high 16 cycles, then fault=1, phase 6, all valves 0. cmd=00 with critico=0 → IDLE.
- critico=1 during RINSE cycle 2 → FAULT next edge, valve_in 0. Holding cmd=00 while critico=1 keeps FAULT; FAULT→IDLE only once critico drops.
- cmd 01→00 at DOSE cycle 3 → IDLE next edge, no adb_done, fault=0. Also: level_low coincident with DRAIN timeout (cycle 16) → RINSE, not FAULT.
- resetN pulsed mid-FLUSH → valve_out drops without clock edge, phase 0, counter 0. cmd=11 in IDLE → no action.

Source files
------------

// File: rtl/tank_actuator_seq.sv
// Tank actuator sequencer: turns the supervisor's irrigation code into timed
// valve sequences (fertilizer dose, or drain/rinse/flush cleaning) and reports
// completion pulses and fault status back to the supervisor.
module tank_actuator_seq #(
  parameter int DOSE_CYCLES  = 8,
  parameter int DRAIN_CYCLES = 16,
  parameter int RINSE_CYCLES = 12,
  parameter int CW           = 5
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [1:0] cmd,
  input  logic       level_low,
  input  logic       level_high,
  input  logic       critico,
  output logic       valve_in,
  output logic       valve_adb,
  output logic       valve_out,
  output logic       adb_done,
  output logic       limp_done,
  output logic       busy,
  output logic       fault,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DOSE  = 3'd1,
    DRAIN = 3'd2,
    RINSE = 3'd3,
    FLUSH = 3'd4,
    HOLD  = 3'd5,
    FAULT = 3'd6
  } state_t;

  localparam logic [1:0] CMD_NADA = 2'b00;
  localparam logic [1:0] CMD_ADB  = 2'b01;
  localparam logic [1:0] CMD_LIMP = 2'b10;

  localparam logic [CW-1:0] DOSE_LAST  = CW'(DOSE_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] RINSE_LAST = CW'(RINSE_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    served;
  logic [1:0]    served_nxt;
  logic          stop_cmd;
  logic          sequencing;

  // Counter increment that sticks at all-ones, so a long HOLD never wraps
  // back to zero and re-fires the done pulse.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign stop_cmd   = (cmd == CMD_NADA) || (cmd == 2'b11);
  assign sequencing = (state == DOSE) || (state == DRAIN) ||
                      (state == RINSE) || (state == FLUSH);

  // State, served-command and in-state cycle counter registers.
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      state  <= IDLE;
      cnt    <= '0;
      served <= CMD_NADA;
    end else begin
      state  <= state_nxt;
      served <= served_nxt;
      cnt    <= (state_nxt != state) ? '0 : sat_inc(cnt);
    end
  end

  // Next state: critico beats abort, abort beats level, level beats timeout.
  always_comb begin
    state_nxt  = state;
    served_nxt = served;
    if (critico && (state != FAULT)) begin
      state_nxt = FAULT;
    end else if (sequencing && stop_cmd) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd == CMD_ADB) begin
            state_nxt  = DOSE;
            served_nxt = CMD_ADB;
          end else if (cmd == CMD_LIMP) begin
            state_nxt  = DRAIN;
            served_nxt = CMD_LIMP;
          end
        end
        DOSE:  if (cnt == DOSE_LAST) state_nxt = HOLD;
        DRAIN: begin
          if (level_low)               state_nxt = RINSE;
          else if (cnt == DRAIN_LAST)  state_nxt = FAULT;
        end
        RINSE: begin
          if (level_high)              state_nxt = FLUSH;
          else if (cnt == RINSE_LAST)  state_nxt = FAULT;
        end
        FLUSH: begin
          if (level_low)               state_nxt = HOLD;
          else if (cnt == DRAIN_LAST)  state_nxt = FAULT;
        end
        HOLD:  if (cmd != served) state_nxt = IDLE;
        FAULT: if ((cmd == CMD_NADA) && !critico) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Moore output decode; done pulses mark the first HOLD cycle (counter 0).
  always_comb begin
    valve_in  = 1'b0;
    valve_adb = 1'b0;
    valve_out = 1'b0;
    adb_done  = 1'b0;
    limp_done = 1'b0;
    busy      = sequencing;
    fault     = (state == FAULT);
    phase     = state;
    case (state)
      DOSE:  valve_adb = 1'b1;
      DRAIN: valve_out = 1'b1;
      FLUSH: valve_out = 1'b1;
      RINSE: valve_in  = 1'b1;
      HOLD: begin
        adb_done  = (cnt == '0) && (served == CMD_ADB);
        limp_done = (cnt == '0) && (served == CMD_LIMP);
      end
      default: ;
    endcase
  end

endmodule
